// File: rtl/dmem_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_pkg                                                        |
// | Purpose  : Shared state encodings and default checker addresses/data.      |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
package dmem_pkg;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_PASS    = 2'd1,
        ST_FAIL    = 2'd2,
        ST_TIMEOUT = 2'd3
    } state_t;

    localparam logic [31:0] c_PASS_ADDR  = 32'd100;
    localparam logic [31:0] c_PASS_DATA  = 32'd7;
    localparam logic [31:0] c_ALLOW_ADDR = 32'd96;

endpackage
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_ram                                                        |
// | Purpose  : DEPTH x 32 storage array, asynchronous read, synchronous write. |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_ram #(
    parameter int DEPTH  = 64,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    logic [31:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
    end

    assign rdata = r_mem[addr];

endmodule
`default_nettype wire

// File: rtl/dmem_store_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : dmem_store_checker                                              |
// | Purpose  : Core data memory that also judges the store stream and reports  |
// |            a sticky pass/fail/timeout verdict for on-board self-check.     |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module dmem_store_checker
    import dmem_pkg::*;
#(
    parameter int          DEPTH       = 64,
    parameter logic [31:0] PASS_ADDR   = c_PASS_ADDR,
    parameter logic [31:0] PASS_DATA   = c_PASS_DATA,
    parameter logic [31:0] ALLOW_ADDR  = c_ALLOW_ADDR,
    parameter int          TIMEOUT_CYC = 1000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] DataAdr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        done,
    output logic        pass,
    output logic [15:0] store_count
);

    localparam int c_ADDR_W = $clog2(DEPTH);
    localparam int c_CNT_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    logic                w_inRange;
    logic [c_ADDR_W-1:0] w_index;
    logic                w_ramWe;
    logic [31:0]         w_ramData;

    state_t              r_state;
    state_t              w_nextState;
    logic                w_cntInc;
    logic [c_CNT_W-1:0]  r_cycleCnt;
    logic [15:0]         r_storeCnt;

    assign w_inRange = (DataAdr[31:c_ADDR_W+2] == '0);
    assign w_index   = DataAdr[c_ADDR_W+1:2];
    // RAM writes ignore the verdict and reset so memory always mirrors the core.
    assign w_ramWe   = MemWrite && w_inRange && (DataAdr[1:0] == 2'b00);

    dmem_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (c_ADDR_W)
    ) u_ram (
        .clk   (clk),
        .we    (w_ramWe),
        .addr  (w_index),
        .wdata (WriteData),
        .rdata (w_ramData)
    );

    assign ReadData = w_inRange ? w_ramData : 32'h0;

    always_comb begin
        w_nextState = r_state;
        w_cntInc    = 1'b0;
        if (r_state == ST_RUN) begin
            if (MemWrite) begin
                if (DataAdr == PASS_ADDR) begin
                    w_nextState = (WriteData == PASS_DATA) ? ST_PASS : ST_FAIL;
                end else if (DataAdr != ALLOW_ADDR) begin
                    w_nextState = ST_FAIL;
                end
            end else if (r_cycleCnt == c_CNT_LAST) begin
                w_nextState = ST_TIMEOUT;
            end else begin
                w_cntInc = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= ST_RUN;
            r_cycleCnt <= '0;
            r_storeCnt <= '0;
        end else begin
            r_state <= w_nextState;
            if (w_cntInc) begin
                r_cycleCnt <= r_cycleCnt + c_CNT_ONE;
            end
            if ((r_state == ST_RUN) && MemWrite && (r_storeCnt != 16'hFFFF)) begin
                r_storeCnt <= r_storeCnt + 16'd1;
            end
        end
    end

    assign done        = (r_state != ST_RUN);
    assign pass        = (r_state == ST_PASS);
    assign store_count = r_storeCnt;

endmodule
`default_nettype wire

// File: tb/tb_dmem_store_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_dmem_store_checker                                           |
// | Purpose  : Directed self-checking bench with an expected-verdict queue.    |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_dmem_store_checker;
    import dmem_pkg::*;

    logic        clk;
    logic        reset;
    logic        MemWrite;
    logic [31:0] DataAdr;
    logic [31:0] WriteData;
    logic [31:0] ReadData,  ReadData8;
    logic        done,      done8;
    logic        pass,      pass8;
    logic [15:0] storeCnt,  storeCnt8;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        string       tag;
        logic        sel;
        logic        done;
        logic        pass;
        logic [15:0] cnt;
    } vexp_t;

    vexp_t expQ[$];

    dmem_store_checker dut (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .ReadData    (ReadData),
        .done        (done),
        .pass        (pass),
        .store_count (storeCnt)
    );

    dmem_store_checker #(.TIMEOUT_CYC(8)) dut8 (
        .clk         (clk),
        .reset       (reset),
        .MemWrite    (MemWrite),
        .DataAdr     (DataAdr),
        .WriteData   (WriteData),
        .ReadData    (ReadData8),
        .done        (done8),
        .pass        (pass8),
        .store_count (storeCnt8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expectVerdict(input string tag, input logic sel, input logic d,
                                 input logic p, input logic [15:0] c);
        vexp_t e;
        e.tag = tag; e.sel = sel; e.done = d; e.pass = p; e.cnt = c;
        expQ.push_back(e);
    endtask

    task automatic checkVerdict();
        vexp_t e;
        logic [17:0] obs;
        logic [17:0] req;
        checks++;
        if (expQ.size() == 0) begin
            failures++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
        end else begin
            e   = expQ.pop_front();
            obs = e.sel ? {done8, pass8, storeCnt8} : {done, pass, storeCnt};
            req = {e.done, e.pass, e.cnt};
            assert (obs === req) else begin
                failures++;
                $error("FAIL %s observed done/pass/cnt=%b/%b/%0d expected=%b/%b/%0d",
                       e.tag, obs[17], obs[16], obs[15:0], req[17], req[16], req[15:0]);
            end
        end
    endtask

    task automatic storeStep(input string tag, input logic [31:0] adr, input logic [31:0] data,
                             input logic d, input logic p, input logic [15:0] c);
        MemWrite  = 1'b1;
        DataAdr   = adr;
        WriteData = data;
        expectVerdict(tag, 1'b0, d, p, c);
        tick();
        MemWrite  = 1'b0;
        checkVerdict();
    endtask

    task automatic checkRead(input string tag, input logic [31:0] adr, input logic [31:0] exp);
        MemWrite = 1'b0;
        DataAdr  = adr;
        #1;
        checks++;
        assert (ReadData === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, ReadData, exp);
        end
    endtask

    task automatic doReset();
        MemWrite = 1'b0;
        reset    = 1'b1;
        tick();
        reset    = 1'b0;
    endtask

    initial begin
        reset     = 1'b1;
        MemWrite  = 1'b0;
        DataAdr   = 32'h0;
        WriteData = 32'h0;
        tick();
        tick();
        reset = 1'b0;
        expectVerdict("reset_state", 1'b0, 1'b0, 1'b0, 16'd0);
        checkVerdict();

        // Legal intermediate stores, then the success store.
        storeStep("allow_1", c_ALLOW_ADDR, 32'd1, 1'b0, 1'b0, 16'd1);
        storeStep("allow_2", c_ALLOW_ADDR, 32'd2, 1'b0, 1'b0, 16'd2);
        storeStep("allow_3", c_ALLOW_ADDR, 32'd3, 1'b0, 1'b0, 16'd3);
        storeStep("pass_store", c_PASS_ADDR, c_PASS_DATA, 1'b1, 1'b1, 16'd4);
        checkRead("mem25_after_pass", 32'd100, 32'd7);
        checkRead("mem24_after_allow", 32'd96, 32'd3);
        storeStep("pass_sticky", 32'h44, 32'h5, 1'b1, 1'b1, 16'd4);

        // Reset pulse from PASS clears the verdict but not the RAM.
        doReset();
        expectVerdict("reset_from_pass", 1'b0, 1'b0, 1'b0, 16'd0);
        checkVerdict();
        checkRead("mem25_kept", 32'd100, 32'd7);

        // Wrong data at the pass address, then the right data is too late.
        storeStep("bad_pass_data", c_PASS_ADDR, 32'd5, 1'b1, 1'b0, 16'd1);
        storeStep("fail_sticky", c_PASS_ADDR, c_PASS_DATA, 1'b1, 1'b0, 16'd1);
        doReset();

        // Store to an unexpected in-range address.
        storeStep("stray_store", 32'h40, 32'd9, 1'b1, 1'b0, 16'd1);
        checkRead("load_0x40", 32'h40, 32'd9);
        storeStep("terminal_write", 32'h0, 32'h11, 1'b1, 1'b0, 16'd1);
        checkRead("terminal_ram_upd", 32'h0, 32'h11);

        // Store during the reset cycle writes RAM but is not judged.
        MemWrite  = 1'b1;
        DataAdr   = 32'h8;
        WriteData = 32'h22;
        reset     = 1'b1;
        tick();
        reset     = 1'b0;
        MemWrite  = 1'b0;
        expectVerdict("reset_cycle_store", 1'b0, 1'b0, 1'b0, 16'd0);
        checkVerdict();
        checkRead("reset_cycle_ram", 32'h8, 32'h22);

        // Out-of-range store: fails, RAM untouched, reads as zero.
        storeStep("allow_a5", c_ALLOW_ADDR, 32'hA5, 1'b0, 1'b0, 16'd1);
        storeStep("out_of_range", 32'h1000, 32'hDEAD, 1'b1, 1'b0, 16'd2);
        checkRead("oor_read_zero", 32'h1000, 32'h0);
        checkRead("oor_no_alias", 32'h0, 32'h11);
        doReset();

        // Misaligned store: fails, mem[24] untouched.
        storeStep("misaligned", 32'h61, 32'hBEEF, 1'b1, 1'b0, 16'd1);
        checkRead("mem24_unchanged", 32'h60, 32'hA5);
        checkRead("read_ignores_lsb", 32'h63, 32'hA5);

        // Timeout on the short-timeout instance.
        doReset();
        for (int i = 0; i < 7; i++) tick();
        expectVerdict("pre_timeout", 1'b1, 1'b0, 1'b0, 16'd0);
        checkVerdict();
        tick();
        expectVerdict("timeout", 1'b1, 1'b1, 1'b0, 16'd0);
        checkVerdict();
        expectVerdict("no_timeout_long", 1'b0, 1'b0, 1'b0, 16'd0);
        checkVerdict();
        tick();
        expectVerdict("timeout_sticky", 1'b1, 1'b1, 1'b0, 16'd0);
        checkVerdict();

        // Store on the timeout edge wins over TIMEOUT.
        doReset();
        for (int i = 0; i < 7; i++) tick();
        MemWrite  = 1'b1;
        DataAdr   = c_PASS_ADDR;
        WriteData = c_PASS_DATA;
        expectVerdict("store_beats_timeout", 1'b1, 1'b1, 1'b1, 16'd1);
        tick();
        MemWrite  = 1'b0;
        checkVerdict();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
